frame_disassembly: RTL and testbench
====================================

# frame_disassembly

Receive-side counterpart of the transmit frame assembler. It decodes a biphase-mark-coded (BMC) serial line carrying S/PDIF-style 32-slot subframes. It detects the B/M/W preambles and recovers the 20-bit audio sample plus the V/U/C bits, with a parity check. It sits behind the input synchronizer on the receiving FPGA and feeds the audio sink with one registered sample per subframe.

## Interface
- `HALF_CLKS`, default 8: `clk` cycles per BMC half-bit cell (1 UI); minimum 4.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `din` in 1: BMC line, already synchronized to `clk`.
- `dout` out 20: audio sample, slot 8 = bit 0 (LSB first).
- `valid` out 1: one-cycle strobe; `dout` and the status outputs are updated on this cycle.
- `channel` out 1: 0 = subframe A (preamble B or M); 1 = subframe B (preamble W).
- `block_start` out 1: subframe began with preamble B.
- `v_bit`, `u_bit`, `c_bit` out 1 each: slots 28, 29, 30.
- `parity_err` out 1: even parity over slots 4–31 failed.
- `lock` out 1: decoder is aligned to subframes.

## Operation
- **Edge detection**
  - `din` is registered into `din_q`; an edge is `din != din_q`.
  - Run counter `run` counts cycles since the last edge. It is set to 1 on an edge and saturates at 4·HALF_CLKS.
- **Run classification** at each edge, with H = HALF_CLKS and integer thresholds:
  - `run < H/2` → BAD.
  - `run < (3H)/2` → R1.
  - `run < (5H)/2` → R2.
  - `run < (7H)/2` → R3.
  - otherwise → BAD.
  - Saturation of `run` (no edge for 4H cycles) is a TIMEOUT error, raised immediately without waiting for an edge.
- **Polarity:** line polarity is ignored; only run lengths matter.
- **FSM states:** HUNT, PRE, DATA.
  - **HUNT:** wait for R3, then go to PRE with `pcnt=0`.
  - **PRE:** collect the next three runs. Preamble patterns:
    - (R1,R1,R3) = B.
    - (R3,R1,R1) = M.
    - (R2,R1,R2) = W.
    - Match → DATA, `slot=4`, parity accumulator cleared, `half=0`.
    - Any other sequence → HUNT, `lock` cleared.
  - **DATA, bit decode:**
    - With `half=0`, R2 decodes bit 0.
    - With `half=0`, R1 sets `half=1`. A following R1 decodes bit 1 and clears `half`.
    - R2 or R3 arriving with `half=1` is an error.
    - R3 or BAD in DATA is an error.
  - Each decoded bit is shifted into slot `slot` and XORed into the parity accumulator; `slot` then increments.
  - After slot 31 is decoded:
    - Register all outputs.
    - Pulse `valid`.
    - Set `parity_err` = accumulator ≠ 0.
    - Set `lock` = 1.
    - Go to PRE with `pcnt=0`. The slot-31 terminating edge is also the start of the next preamble's R3, so the next R3 is expected as the first pending run.
- **Preamble run counting:** the first R3 of a preamble is consumed by the HUNT→PRE (or DATA→PRE) transition; PRE then takes exactly three further runs.
- **Errors** (BAD, TIMEOUT, illegal run in PRE or DATA):
  - Go to HUNT and clear `lock` on the next cycle.
  - No `valid` is produced for the partial subframe.
  - `dout` and the status outputs hold their last values.
- **Aux slots:** slots 4–7 are decoded and included in parity, then discarded.

## Timing
- **Reset** (`rst`=0 at a `clk` edge):
  - State HUNT; `run`=0, `din_q`=`din`.
  - All outputs 0: `dout`=0, `valid`=0, `channel`=0, `block_start`=0, `v_bit`/`u_bit`/`c_bit`=0, `parity_err`=0, `lock`=0.
  - Reset asserted mid-subframe discards the subframe; no `valid`.
- **Latency:** `valid` is high exactly one cycle after the cycle in which the edge terminating slot 31 is detected. `valid` is never high on consecutive cycles.
- **Output hold:** all outputs other than `valid` hold until the next `valid`, error, or reset.
- **Edge ordering:** an edge in the same cycle as `run` saturation is treated as TIMEOUT.
- **Jitter:** each run tolerates ±(H/2 − 1) cycles of deviation.

## Test plan
1. **Reset:** hold `rst`=0 for 5 cycles while toggling `din` → all outputs 0, no `valid`. Release, then send a valid B subframe → first `valid` appears and `lock` rises.
2. **B subframe decode** (H=8): B subframe, audio 20'hABCDE, aux 0, V=0, U=1, C=1, correct P → single `valid` one cycle after the final edge, with:
   - `dout`=20'hABCDE, `channel`=0, `block_start`=1;
   - `u_bit`=1, `c_bit`=1, `v_bit`=0;
   - `parity_err`=0, `lock`=1.
3. **W then M subframes:** W subframe with 20'h12345 → `channel`=1, `block_start`=0. Following M subframe with 20'h00001 → `channel`=0, `block_start`=0, `dout`=20'h00001. Repeat with the line inverted → identical outputs.
4. **Parity error:** flip the P bit of a 20'hFFFFF subframe → `valid` with `dout`=20'hFFFFF, `parity_err`=1, `lock` stays 1. Next good subframe → `parity_err`=0.
5. **Timeout:** hold `din` constant for 32 cycles at slot 15 → `lock`=0 and no `valid`; `dout` keeps the previous value. A next complete B subframe decodes correctly.
6. **Jitter and width errors:** runs of 5/11/19/27 cycles are accepted as R1/R1/R2/R3 and decode correctly. A 3-cycle run → BAD: `lock`=0, state HUNT.

Source files
------------

// File: rtl/frame_disassembly.sv
// frame_disassembly: BMC subframe decoder. It finds the B/M/W preambles and
// recovers the 20-bit audio sample, the V/U/C bits and the parity status.
module frame_disassembly #(
   parameter int unsigned HALF_CLKS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   output logic [19:0] dout,
   output logic        valid,
   output logic        channel,
   output logic        block_start,
   output logic        v_bit,
   output logic        u_bit,
   output logic        c_bit,
   output logic        parity_err,
   output logic        lock
);

   localparam int unsigned RUN_MAX = 4 * HALF_CLKS;
   localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
   localparam int unsigned T_R1    = HALF_CLKS / 2;
   localparam int unsigned T_R2    = (3 * HALF_CLKS) / 2;
   localparam int unsigned T_R3    = (5 * HALF_CLKS) / 2;
   localparam int unsigned T_BAD   = (7 * HALF_CLKS) / 2;
   localparam int unsigned SLOT_W  = 5;
   localparam int unsigned SHIFT_W = 23;

   typedef enum logic [1:0] {S_HUNT, S_PRE, S_DATA} state_t;
   typedef enum logic [1:0] {C_BAD, C_R1, C_R2, C_R3} run_t;

   logic               r_din_q;
   logic [RUN_W-1:0]   r_run;
   state_t             r_state, w_state_d;
   logic [1:0]         r_pcnt, w_pcnt_d;
   logic               r_need_r3, w_need_d;
   run_t               r_p0, w_p0_d, r_p1, w_p1_d;
   logic               r_chan, w_chan_d, r_bstart, w_bstart_d;
   logic [SLOT_W-1:0]  r_slot, w_slot_d;
   logic               r_half, w_half_d, r_par, w_par_d;
   logic [SHIFT_W-1:0] r_shift, w_shift_d;
   logic [19:0]        r_dout, w_dout_d;
   logic               r_valid, w_valid_d, r_channel, w_channel_d;
   logic               r_block_start, w_block_start_d;
   logic               r_v, w_v_d, r_u, w_u_d, r_c, w_c_d;
   logic               r_perr, w_perr_d, r_lock, w_lock_d;
   logic               w_edge, w_timeout, w_err, w_bit_en, w_bit_val, w_start;
   run_t               w_cls;

   assign w_edge    = din ^ r_din_q;
   assign w_timeout = (r_run == RUN_W'(RUN_MAX));

   // Line history and saturating run-length counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_din_q <= din;
         r_run   <= '0;
      end else begin
         r_din_q <= din;
         if (w_edge)          r_run <= RUN_W'(1);
         else if (!w_timeout) r_run <= r_run + RUN_W'(1);
      end
   end

   // Classify the run that ends at the current edge.
   always_comb begin
      w_cls = C_BAD;
      if (r_run < RUN_W'(T_R1))       w_cls = C_BAD;
      else if (r_run < RUN_W'(T_R2))  w_cls = C_R1;
      else if (r_run < RUN_W'(T_R3))  w_cls = C_R2;
      else if (r_run < RUN_W'(T_BAD)) w_cls = C_R3;
      else                            w_cls = C_BAD;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= S_HUNT;
         r_pcnt        <= '0;
         r_need_r3     <= 1'b0;
         r_p0          <= C_BAD;
         r_p1          <= C_BAD;
         r_chan        <= 1'b0;
         r_bstart      <= 1'b0;
         r_slot        <= '0;
         r_half        <= 1'b0;
         r_par         <= 1'b0;
         r_shift       <= '0;
         r_dout        <= '0;
         r_valid       <= 1'b0;
         r_channel     <= 1'b0;
         r_block_start <= 1'b0;
         r_v           <= 1'b0;
         r_u           <= 1'b0;
         r_c           <= 1'b0;
         r_perr        <= 1'b0;
         r_lock        <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_pcnt        <= w_pcnt_d;
         r_need_r3     <= w_need_d;
         r_p0          <= w_p0_d;
         r_p1          <= w_p1_d;
         r_chan        <= w_chan_d;
         r_bstart      <= w_bstart_d;
         r_slot        <= w_slot_d;
         r_half        <= w_half_d;
         r_par         <= w_par_d;
         r_shift       <= w_shift_d;
         r_dout        <= w_dout_d;
         r_valid       <= w_valid_d;
         r_channel     <= w_channel_d;
         r_block_start <= w_block_start_d;
         r_v           <= w_v_d;
         r_u           <= w_u_d;
         r_c           <= w_c_d;
         r_perr        <= w_perr_d;
         r_lock        <= w_lock_d;
      end
   end

   // Next state: preamble match, bit decode, subframe completion, errors.
   always_comb begin
      w_state_d       = r_state;
      w_pcnt_d        = r_pcnt;
      w_need_d        = r_need_r3;
      w_p0_d          = r_p0;
      w_p1_d          = r_p1;
      w_chan_d        = r_chan;
      w_bstart_d      = r_bstart;
      w_slot_d        = r_slot;
      w_half_d        = r_half;
      w_par_d         = r_par;
      w_shift_d       = r_shift;
      w_dout_d        = r_dout;
      w_valid_d       = 1'b0;
      w_channel_d     = r_channel;
      w_block_start_d = r_block_start;
      w_v_d           = r_v;
      w_u_d           = r_u;
      w_c_d           = r_c;
      w_perr_d        = r_perr;
      w_lock_d        = r_lock;
      w_err           = 1'b0;
      w_bit_en        = 1'b0;
      w_bit_val       = 1'b0;
      w_start         = 1'b0;

      if (w_timeout) begin
         w_err = 1'b1;
      end else if (w_edge) begin
         case (r_state)
            S_HUNT: begin
               if (w_cls == C_R3) begin
                  w_state_d = S_PRE;
                  w_pcnt_d  = 2'd0;
                  w_need_d  = 1'b0;
               end
            end
            S_PRE: begin
               if (w_cls == C_BAD) begin
                  w_err = 1'b1;
               end else if (r_need_r3) begin
                  // Leading R3 started by the previous subframe's last edge.
                  if (w_cls == C_R3) w_need_d = 1'b0;
                  else               w_err    = 1'b1;
               end else begin
                  case (r_pcnt)
                     2'd0: begin
                        w_p0_d   = w_cls;
                        w_pcnt_d = 2'd1;
                     end
                     2'd1: begin
                        w_p1_d   = w_cls;
                        w_pcnt_d = 2'd2;
                     end
                     default: begin
                        if (r_p0 == C_R1 && r_p1 == C_R1 && w_cls == C_R3) begin
                           w_chan_d   = 1'b0;
                           w_bstart_d = 1'b1;
                           w_start    = 1'b1;
                        end else if (r_p0 == C_R3 && r_p1 == C_R1 && w_cls == C_R1) begin
                           w_chan_d   = 1'b0;
                           w_bstart_d = 1'b0;
                           w_start    = 1'b1;
                        end else if (r_p0 == C_R2 && r_p1 == C_R1 && w_cls == C_R2) begin
                           w_chan_d   = 1'b1;
                           w_bstart_d = 1'b0;
                           w_start    = 1'b1;
                        end else begin
                           w_err = 1'b1;
                        end
                     end
                  endcase
               end
               if (w_start) begin
                  w_state_d = S_DATA;
                  w_slot_d  = SLOT_W'(4);
                  w_par_d   = 1'b0;
                  w_half_d  = 1'b0;
               end
            end
            S_DATA: begin
               if (!r_half) begin
                  if (w_cls == C_R2) begin
                     w_bit_en  = 1'b1;
                     w_bit_val = 1'b0;
                  end else if (w_cls == C_R1) begin
                     w_half_d = 1'b1;
                  end else begin
                     w_err = 1'b1;
                  end
               end else begin
                  if (w_cls == C_R1) begin
                     w_bit_en  = 1'b1;
                     w_bit_val = 1'b1;
                     w_half_d  = 1'b0;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            default: w_err = 1'b1;
         endcase
      end

      // Store the decoded bit; slot 31 (parity) completes the subframe.
      if (w_bit_en) begin
         if (r_slot == SLOT_W'(31)) begin
            w_valid_d       = 1'b1;
            w_dout_d        = r_shift[19:0];
            w_v_d           = r_shift[20];
            w_u_d           = r_shift[21];
            w_c_d           = r_shift[22];
            w_perr_d        = r_par ^ w_bit_val;
            w_channel_d     = r_chan;
            w_block_start_d = r_bstart;
            w_lock_d        = 1'b1;
            w_state_d       = S_PRE;
            w_pcnt_d        = 2'd0;
            w_need_d        = 1'b1;
         end else begin
            w_par_d = r_par ^ w_bit_val;
            if (r_slot >= SLOT_W'(8)) w_shift_d = {w_bit_val, r_shift[SHIFT_W-1:1]};
            w_slot_d = r_slot + SLOT_W'(1);
         end
      end

      if (w_err) begin
         w_state_d = S_HUNT;
         w_lock_d  = 1'b0;
      end
   end

   assign dout        = r_dout;
   assign valid       = r_valid;
   assign channel     = r_channel;
   assign block_start = r_block_start;
   assign v_bit       = r_v;
   assign u_bit       = r_u;
   assign c_bit       = r_c;
   assign parity_err  = r_perr;
   assign lock        = r_lock;

endmodule

// File: tb/tb_frame_disassembly.sv
// tb_frame_disassembly: scoreboard bench for the BMC subframe decoder.
module tb_frame_disassembly;

   localparam int unsigned H = 8;

   typedef struct packed {
      logic [19:0] dout;
      logic        ch;
      logic        bs;
      logic        v;
      logic        u;
      logic        c;
      logic        perr;
      logic        lk;
      logic [31:0] cyc;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        din = 1'b0;
   logic [19:0] dout;
   logic        valid, channel, block_start, v_bit, u_bit, c_bit, parity_err, lock;

   rec_t        exp_q[$];
   rec_t        obs_q[$];
   int          runs[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_valid  = 0;
   int          n_consec = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] cyc = 0;
   logic [31:0] last_edge = 0;

   frame_disassembly #(.HALF_CLKS(H)) dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout), .valid(valid),
      .channel(channel), .block_start(block_start), .v_bit(v_bit),
      .u_bit(u_bit), .c_bit(c_bit), .parity_err(parity_err), .lock(lock)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   // Capture every valid strobe with its cycle number.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         obs_q.push_back({dout, channel, block_start, v_bit, u_bit, c_bit,
                          parity_err, lock, cyc});
         n_valid <= n_valid + 1;
         if (prev_valid) n_consec <= n_consec + 1;
      end
      prev_valid <= (valid === 1'b1);
   end

   function automatic int ui(input int n, input bit jit, input bit ph);
      if (!jit) return n * H;
      if (n == 1) return ph ? 11 : 5;
      if (n == 2) return 19;
      return 27;
   endfunction

   // Build run list (cycles) for preamble plus slots 4..last_slot.
   // ptype: 0 = B, 1 = M, 2 = W. vuc = {V, U, C}.
   task automatic build(input int ptype, input logic [19:0] audio, input logic [2:0] vuc,
                        input logic flip_p, input int last_slot, input bit jit);
      logic [31:0] sf;
      int          pre[4];
      bit          ph;
      ph = 1'b0;
      sf = '0;
      sf[27:8] = audio;
      sf[28]   = vuc[2];
      sf[29]   = vuc[1];
      sf[30]   = vuc[0];
      sf[31]   = (^sf[30:4]) ^ flip_p;
      runs.delete();
      case (ptype)
         0:       pre = '{3, 1, 1, 3};
         1:       pre = '{3, 3, 1, 1};
         default: pre = '{3, 2, 1, 2};
      endcase
      for (int i = 0; i < 4; i++) begin
         runs.push_back(ui(pre[i], jit, ph));
         if (pre[i] == 1) ph = ~ph;
      end
      for (int s = 4; s <= last_slot; s++) begin
         if (sf[s]) begin
            runs.push_back(ui(1, jit, ph)); ph = ~ph;
            runs.push_back(ui(1, jit, ph)); ph = ~ph;
         end else begin
            runs.push_back(ui(2, jit, ph));
         end
      end
   endtask

   task automatic play(input bit lead);
      if (lead) begin
         @(negedge clk);
         din = ~din;
      end
      for (int i = 0; i < runs.size(); i++) begin
         repeat (runs[i]) @(negedge clk);
         din = ~din;
         last_edge = cyc;
      end
   endtask

   task automatic push_exp(input logic [19:0] d, input logic ch, input logic bs,
                           input logic [2:0] vuc, input logic perr);
      exp_q.push_back({d, ch, bs, vuc, perr, 1'b1, last_edge + 32'd1});
   endtask

   task automatic get_obs(output rec_t e, output rec_t o, output bit got);
      got = 1'b0;
      e   = '0;
      o   = '0;
      for (int k = 0; k < 300; k++) begin
         if (obs_q.size() != 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) begin
         o   = obs_q.pop_front();
         got = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rec_t e, o;
      bit   got;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         din = ~din;
      end
      @(negedge clk);
      n_checks++;
      if ({dout, valid, channel, block_start, v_bit, u_bit, c_bit, parity_err, lock} !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0",
                  {dout, valid, channel, block_start, v_bit, u_bit, c_bit, parity_err, lock});
      end
      n_checks++;
      if (n_valid !== 0) begin
         n_fail++;
         $display("FAIL reset_no_valid: got %0d want 0", n_valid);
      end
      rst = 1'b1;
      idle(40);
      build(0, 20'h13579, 3'b000, 1'b0, 31, 1'b0);
      play(1'b1);
      push_exp(20'h13579, 1'b0, 1'b1, 3'b000, 1'b0);
      get_obs(e, o, got);
      n_checks++;
      if (!got || o !== e) begin
         n_fail++;
         $display("FAIL first_after_reset: got %h want %h", o, e);
      end
      n_checks++;
      if (lock !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_rise: got %b want 1", lock);
      end
   endtask

   task automatic test_b_decode();
      rec_t e, o;
      bit   got;
      idle(40);
      build(0, 20'hABCDE, 3'b011, 1'b0, 31, 1'b0);
      play(1'b1);
      push_exp(20'hABCDE, 1'b0, 1'b1, 3'b011, 1'b0);
      get_obs(e, o, got);
      n_checks++;
      if (!got || o !== e) begin
         n_fail++;
         $display("FAIL b_subframe: got %h want %h", o, e);
      end
   endtask

   task automatic test_w_m(input logic inv);
      rec_t e, o;
      bit   got;
      idle(5);
      din = inv;
      idle(40);
      build(2, 20'h12345, 3'b000, 1'b0, 31, 1'b0);
      play(1'b1);
      push_exp(20'h12345, 1'b1, 1'b0, 3'b000, 1'b0);
      build(1, 20'h00001, 3'b000, 1'b0, 31, 1'b0);
      play(1'b0);
      push_exp(20'h00001, 1'b0, 1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         get_obs(e, o, got);
         n_checks++;
         if (!got || o !== e) begin
            n_fail++;
            $display("FAIL w_m_inv%0d_frame%0d: got %h want %h", inv, i, o, e);
         end
      end
   endtask

   task automatic test_parity();
      rec_t e, o;
      bit   got;
      idle(40);
      build(0, 20'hFFFFF, 3'b000, 1'b1, 31, 1'b0);
      play(1'b1);
      push_exp(20'hFFFFF, 1'b0, 1'b1, 3'b000, 1'b1);
      build(2, 20'h0F0F0, 3'b101, 1'b0, 31, 1'b0);
      play(1'b0);
      push_exp(20'h0F0F0, 1'b1, 1'b0, 3'b101, 1'b0);
      for (int i = 0; i < 2; i++) begin
         get_obs(e, o, got);
         n_checks++;
         if (!got || o !== e) begin
            n_fail++;
            $display("FAIL parity_frame%0d: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_timeout();
      rec_t e, o;
      bit   got;
      int   vcount;
      idle(40);
      build(0, 20'h55555, 3'b001, 1'b0, 31, 1'b0);
      play(1'b1);
      push_exp(20'h55555, 1'b0, 1'b1, 3'b001, 1'b0);
      build(1, 20'h2AAAA, 3'b000, 1'b0, 14, 1'b0);
      play(1'b0);
      n_checks++;
      if (lock !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_lock_before: got %b want 1", lock);
      end
      get_obs(e, o, got);
      n_checks++;
      if (!got || o !== e) begin
         n_fail++;
         $display("FAIL timeout_prev_frame: got %h want %h", o, e);
      end
      vcount = n_valid;
      idle(40);
      n_checks++;
      if (lock !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_lock: got %b want 0", lock);
      end
      n_checks++;
      if (dout !== 20'h55555) begin
         n_fail++;
         $display("FAIL timeout_dout_hold: got %h want 55555", dout);
      end
      n_checks++;
      if (n_valid !== vcount) begin
         n_fail++;
         $display("FAIL timeout_no_valid: got %0d want %0d", n_valid, vcount);
      end
      build(0, 20'h3C3C3, 3'b100, 1'b0, 31, 1'b0);
      play(1'b1);
      push_exp(20'h3C3C3, 1'b0, 1'b1, 3'b100, 1'b0);
      get_obs(e, o, got);
      n_checks++;
      if (!got || o !== e) begin
         n_fail++;
         $display("FAIL timeout_recover: got %h want %h", o, e);
      end
   endtask

   task automatic test_jitter_bad();
      rec_t e, o;
      bit   got;
      int   vcount;
      idle(40);
      build(0, 20'hABC12, 3'b010, 1'b0, 31, 1'b1);
      play(1'b1);
      push_exp(20'hABC12, 1'b0, 1'b1, 3'b010, 1'b0);
      build(2, 20'h54321, 3'b111, 1'b0, 31, 1'b1);
      play(1'b0);
      push_exp(20'h54321, 1'b1, 1'b0, 3'b111, 1'b0);
      build(2, 20'h77777, 3'b000, 1'b0, 12, 1'b0);
      play(1'b0);
      n_checks++;
      if (lock !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_lock_before: got %b want 1", lock);
      end
      for (int i = 0; i < 2; i++) begin
         get_obs(e, o, got);
         n_checks++;
         if (!got || o !== e) begin
            n_fail++;
            $display("FAIL jitter_frame%0d: got %h want %h", i, o, e);
         end
      end
      vcount = n_valid;
      repeat (3) @(negedge clk);
      din = ~din;
      idle(4);
      n_checks++;
      if (lock !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_run_lock: got %b want 0", lock);
      end
      idle(60);
      n_checks++;
      if (n_valid !== vcount) begin
         n_fail++;
         $display("FAIL bad_run_no_valid: got %0d want %0d", n_valid, vcount);
      end
      build(0, 20'hC0FFE, 3'b011, 1'b0, 31, 1'b0);
      play(1'b1);
      push_exp(20'hC0FFE, 1'b0, 1'b1, 3'b011, 1'b0);
      get_obs(e, o, got);
      n_checks++;
      if (!got || o !== e) begin
         n_fail++;
         $display("FAIL bad_recover: got %h want %h", o, e);
      end
   endtask

   task automatic test_final();
      idle(10);
      n_checks++;
      if (n_consec !== 0) begin
         n_fail++;
         $display("FAIL back_to_back_valid: got %0d want 0", n_consec);
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL extra_valid: got %0d want 0", obs_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_b_decode();
      test_w_m(1'b0);
      test_w_m(1'b1);
      test_parity();
      test_timeout();
      test_jitter_bad();
      test_final();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
